count_seg7_display: RTL and testbench
=====================================

// Module: count_seg7_display
// PURPOSE
//  Downstream display stage for the debounced button counter: accepts the 8-bit count on a
//  load strobe and converts it to BCD with a sequential double-dabble engine.
//  Time-multiplexes hundreds/tens/ones onto a 4-digit common-anode 7-segment display.
//  Sits between the counter output and the board's seg/anode pins.
// PARAMETERS
//  REFRESH_DIV   32'd100_000   clk cycles per digit slot (1 ms at 100 MHz); legal range >= 2
// PORTS
//  clk          in   1  system clock, all logic on posedge
//  reset        in   1  synchronous, active-high
//  value        in   8  binary count to display (0..255)
//  value_valid  in   1  load strobe, one-cycle pulse; value sampled on the same edge
//  busy         out  1  high while a conversion is in progress
//  seg          out  7  segments {g,f,e,d,c,b,a}, active-low
//  dp           out  1  decimal point, active-low; constant 1 (off)
//  an           out  4  digit enables, active-low; an[0]=ones, an[1]=tens, an[2]=hundreds
// BEHAVIOUR
//  Reset: seg=7'h7F, an=4'hF, dp=1, busy=0, displayed BCD=12'h000, pending flag=0,
//   refresh counter=0, digit index=0, converter FSM=IDLE.
//  Converter FSM: IDLE -> SHIFT -> DONE -> IDLE.
//   IDLE: value_valid=1 loads shift register {12'h000, value}, iteration count=0, goes to SHIFT.
//   SHIFT: each cycle, add 3 to every BCD nibble >= 5, then shift left 1; 8 cycles total.
//   DONE: copy BCD result to the display register (visible from the next cycle); go to IDLE.
//  Latency: value_valid at edge N -> display register updated at edge N+10.
//  busy = (state != IDLE); registered, so it is high from N+1 through N+9.
//  value_valid while busy: value goes to a pending register and the pending flag is set
//   (last write wins). In DONE with pending set, the next state is SHIFT, the pending value
//   is loaded and the flag is cleared. busy stays high with no gap.
//  value_valid in DONE counts as a pending write.
//  Scan: refresh counter 0..REFRESH_DIV-1, wraps. On wrap, digit index goes 0->1->2->0.
//   an[3] is always 1.
//  seg/an are registered and change together one cycle after the digit index changes.
//   There is no cycle where the new anode is driven with the old segment pattern.
//  Digit decode: 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 (hex); blank=7F.
//   Nibbles > 9 cannot occur (8-bit input, max 255); decode them as blank.
//  Reset mid-conversion: FSM returns to IDLE, result discarded, pending cleared,
//   display returns to 000 or blank.
// CONFIGURATION
//  LEADING_ZERO_BLANK_EN defined: a hundreds digit of 0 drives seg=7F. A tens digit of 0
//   also drives seg=7F when the hundreds digit is 0. The ones digit is always shown,
//   so value 0 displays "  0".
//   The anode still cycles for blanked digits, so brightness stays uniform.
//  Not defined: all three digits are always shown (value 5 displays "005").
// STRUCTURE
//  Package seg7_pkg: converter state enum (IDLE/SHIFT/DONE), SEG_BLANK=7'h7F,
//   10-entry digit-to-segment constant table, DIGIT_CNT=3.
//  Sub-module bin2bcd_seq: the converter FSM plus the pending register.
//   Ports: clk, reset, start, bin[7:0], busy, done, bcd[11:0].
//  Top level: refresh counter, digit index, blanking logic, segment decode and output registers.
// TESTING  (bench overrides REFRESH_DIV=4)
//  1. Assert reset 3 cycles -> seg=7F, an=F, dp=1, busy=0. Release -> first lit slot is an=E, seg=40 ("0").
//  2. value=255 pulse at edge N -> busy high N+1..N+9; scan shows an=B seg=24, an=D seg=12, an=E seg=12.
//  3. value=7 without the macro -> digits 40,40,78. With LEADING_ZERO_BLANK_EN -> 7F,7F,78.
//  4. value=100, then value=42 at N+3 -> busy held continuously; the final display is 0,4,2.
//     100 is never latched to the display.
//  5. reset asserted at N+4 of a conversion of 199 -> busy=0 the next cycle; display shows 000 or blank.
//  6. Scan wrap: over 12 REFRESH_DIV slots, an cycles E,D,B with period 12 cycles.
//     an[3] stays 1 and at most one an bit is low at a time.

Source files
------------

// File: rtl/seg7_pkg.sv
// seg7_pkg: shared definitions for the count_seg7_display slice.
//   conv_state_t  - converter FSM states (IDLE/SHIFT/DONE)
//   SEG_BLANK     - all segments off (active-low)
//   SEG_TABLE     - digit 0..9 to {g,f,e,d,c,b,a} pattern, active-low
//   DIGIT_CNT     - number of BCD digits driven (hundreds/tens/ones)
//   bcd_adjust    - double-dabble "add 3 if >= 5" step over all digits
//   seg_decode    - digit to segment pattern, out-of-range digits blank
package seg7_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } conv_state_t;

  localparam int          DIGIT_CNT = 3;
  localparam logic [6:0]  SEG_BLANK = 7'h7F;

  // Entry [0] is the least significant element, so digit 0 sits last.
  localparam logic [9:0][6:0] SEG_TABLE = {
    7'h10, 7'h00, 7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  function automatic logic [11:0] bcd_adjust(input logic [11:0] b);
    logic [11:0] r;
    r = b;
    for (int i = 0; i < DIGIT_CNT; i++)
      if (b[4*i +: 4] >= 4'd5) r[4*i +: 4] = b[4*i +: 4] + 4'd3;
    return r;
  endfunction

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    return (d <= 4'd9) ? SEG_TABLE[d] : SEG_BLANK;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble converter, 8-bit binary to 3-digit BCD.
//   clk, reset  - clock, synchronous active-high reset
//   start       - load strobe; while busy it is captured as a pending request
//   bin[7:0]    - binary value sampled with start
//   busy        - registered (state != IDLE)
//   done        - one-cycle pulse; bcd holds a fresh result from that cycle on
//   bcd[11:0]   - {hundreds, tens, ones}
// A request arriving mid-conversion (last one wins) is chained straight from
// DONE back into SHIFT, and the superseded result is never published.
module bin2bcd_seq
  import seg7_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  bin,
  output logic        busy,
  output logic        done,
  output logic [11:0] bcd
);

  conv_state_t state;
  logic [19:0] sr;        // {bcd[11:0], bin[7:0]}
  logic [2:0]  iter;
  logic        pend;
  logic [7:0]  pend_val;
  logic [11:0] adj;

  always_comb adj = bcd_adjust(sr[19:8]);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      sr       <= '0;
      iter     <= '0;
      pend     <= 1'b0;
      pend_val <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      bcd      <= '0;
    end else begin
      busy <= (state != IDLE);
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          sr    <= {12'h000, bin};
          iter  <= '0;
          state <= SHIFT;
        end
        SHIFT: begin
          if (start) begin
            pend     <= 1'b1;
            pend_val <= bin;
          end
          sr   <= {adj, sr[7:0]} << 1;
          iter <= iter + 3'd1;
          if (iter == 3'd7) state <= DONE;
        end
        DONE: begin
          // A strobe landing in DONE is newer than any pending value.
          if (start || pend) begin
            sr    <= {12'h000, (start ? bin : pend_val)};
            iter  <= '0;
            pend  <= 1'b0;
            state <= SHIFT;
          end else begin
            bcd   <= sr[19:8];
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/count_seg7_display.sv
// count_seg7_display: latches an 8-bit count, converts it to BCD and scans
// hundreds/tens/ones onto a 4-digit common-anode 7-segment display.
//   clk, reset   - clock, synchronous active-high reset
//   value[7:0]   - count to display, sampled when value_valid is high
//   value_valid  - one-cycle load strobe
//   busy         - conversion in progress
//   seg[6:0]     - {g,f,e,d,c,b,a}, active-low
//   dp           - decimal point, active-low, held off
//   an[3:0]      - digit enables, active-low; an[0]=ones .. an[2]=hundreds, an[3] unused
// Parameter REFRESH_DIV: clk cycles per digit slot (>= 2).
// Optional macro LEADING_ZERO_BLANK_EN: blank a leading zero hundreds digit,
// and the tens digit too when both are zero; the ones digit is always shown.
module count_seg7_display
  import seg7_pkg::*;
#(
  parameter logic [31:0] REFRESH_DIV = 32'd100_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] value,
  input  logic       value_valid,
  output logic       busy,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] an
);

  logic        conv_done;
  logic [11:0] conv_bcd;
  logic [11:0] disp;
  logic [31:0] ref_cnt;
  logic [1:0]  dig_idx;
  logic        hund_blank, tens_blank;
  logic [3:0]  nib;
  logic        nib_blank;
  logic [3:0]  an_nxt;
  logic [6:0]  seg_nxt;

  bin2bcd_seq u_conv (
    .clk   (clk),
    .reset (reset),
    .start (value_valid),
    .bin   (value),
    .busy  (busy),
    .done  (conv_done),
    .bcd   (conv_bcd)
  );

  always_ff @(posedge clk) begin
    if (reset)          disp <= '0;
    else if (conv_done) disp <= conv_bcd;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ref_cnt <= '0;
      dig_idx <= '0;
    end else if (ref_cnt == REFRESH_DIV - 32'd1) begin
      ref_cnt <= '0;
      dig_idx <= (dig_idx == 2'd2) ? 2'd0 : dig_idx + 2'd1;
    end else begin
      ref_cnt <= ref_cnt + 32'd1;
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  assign hund_blank = (disp[11:8] == 4'd0);
  assign tens_blank = hund_blank && (disp[7:4] == 4'd0);
`else
  assign hund_blank = 1'b0;
  assign tens_blank = 1'b0;
`endif

  always_comb begin
    nib       = disp[3:0];
    nib_blank = 1'b0;
    an_nxt    = 4'hF;
    case (dig_idx)
      2'd0: begin nib = disp[3:0];  an_nxt = 4'b1110; end
      2'd1: begin nib = disp[7:4];  an_nxt = 4'b1101; nib_blank = tens_blank; end
      2'd2: begin nib = disp[11:8]; an_nxt = 4'b1011; nib_blank = hund_blank; end
      default: nib_blank = 1'b1;
    endcase
    seg_nxt = nib_blank ? SEG_BLANK : seg_decode(nib);
  end

  // Segment pattern and anode are registered together, so a new anode is
  // never driven with the previous digit's pattern.
  always_ff @(posedge clk) begin
    if (reset) begin
      seg <= SEG_BLANK;
      an  <= 4'hF;
    end else begin
      seg <= seg_nxt;
      an  <= an_nxt;
    end
  end

  assign dp = 1'b1;

endmodule

// File: tb/tb_count_seg7_display.sv
// Directed bench for count_seg7_display with REFRESH_DIV=4 (12-cycle scan).
module tb_count_seg7_display;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] value = '0;
  logic       value_valid = 1'b0;
  logic       busy;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;

  int checks = 0;
  int errors = 0;

  count_seg7_display #(.REFRESH_DIV(32'd4)) dut (
    .clk         (clk),
    .reset       (reset),
    .value       (value),
    .value_valid (value_valid),
    .busy        (busy),
    .seg         (seg),
    .dp          (dp),
    .an          (an)
  );

  always #5 clk = ~clk;

`ifdef LEADING_ZERO_BLANK_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse(input logic [7:0] v);
    @(negedge clk); value = v; value_valid = 1'b1;
    @(negedge clk); value_valid = 1'b0;
  endtask

  // One full scan period; returns the pattern seen in each digit slot.
  task automatic scan(output logic [6:0] h, output logic [6:0] t, output logic [6:0] o);
    h = 'x; t = 'x; o = 'x;
    repeat (12) begin
      @(negedge clk);
      check("an3_high", {31'd0, an[3]}, 32'd1);
      check("an_onehot", {31'd0, ($countones(~an) <= 1)}, 32'd1);
      case (an)
        4'hE: o = seg;
        4'hD: t = seg;
        4'hB: h = seg;
        default: ;
      endcase
    end
  endtask

  task automatic check_digits(input string tag, input logic [6:0] eh, input logic [6:0] et, input logic [6:0] eo);
    logic [6:0] h, t, o;
    scan(h, t, o);
    check({tag, "_hund"}, {25'd0, h}, {25'd0, eh});
    check({tag, "_tens"}, {25'd0, t}, {25'd0, et});
    check({tag, "_ones"}, {25'd0, o}, {25'd0, eo});
  endtask

  // Counts negedges with busy high, starting from the current one.
  task automatic busy_run(output int n);
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    int n;
    logic [3:0] prev;
    logic seen_one;
    logic [3:0] exp_an;
    bit found;

    // 1. reset state, then first lit slot
    repeat (3) @(negedge clk);
    check("rst_seg", {25'd0, seg}, 32'h7F);
    check("rst_an", {28'd0, an}, 32'hF);
    check("rst_dp", {31'd0, dp}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("first_an", {28'd0, an}, 32'hE);
    check("first_seg", {25'd0, seg}, 32'h40);

    // 2. value 255: busy high for edges N+1..N+9
    pulse(8'd255);
    check("busy_n0", {31'd0, busy}, 32'd0);
    @(negedge clk);
    busy_run(n);
    check("busy_len_255", n, 32'd9);
    repeat (2) @(negedge clk);
    check_digits("v255", 7'h24, 7'h12, 7'h12);
    check("dp_off", {31'd0, dp}, 32'd1);

    // 3. value 7, leading zeros depend on blanking
    pulse(8'd7);
    repeat (14) @(negedge clk);
    check_digits("v7", LZB ? 7'h7F : 7'h40, LZB ? 7'h7F : 7'h40, 7'h78);

    // 4. 100 superseded by 42 mid-conversion
    pulse(8'd100);
    @(negedge clk);
    check("chain_busy_n1", {31'd0, busy}, 32'd1);
    pulse(8'd42);
    seen_one = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      if (an == 4'hB && seg == 7'h79) seen_one = 1'b1;
      @(negedge clk);
    end
    check("chain_busy_len", n, 32'd16);
    repeat (12) begin
      @(negedge clk);
      if (an == 4'hB && seg == 7'h79) seen_one = 1'b1;
    end
    check("no_100_latched", {31'd0, seen_one}, 32'd0);
    check_digits("v42", LZB ? 7'h7F : 7'h40, 7'h19, 7'h24);

    // 5. reset during conversion of 199
    pulse(8'd199);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_seg", {25'd0, seg}, 32'h7F);
    check("midrst_an", {28'd0, an}, 32'hF);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    check("midrst_busy_idle", {31'd0, busy}, 32'd0);
    check_digits("midrst", LZB ? 7'h7F : 7'h40, LZB ? 7'h7F : 7'h40, 7'h40);

    // 6. scan order and period: E x4, D x4, B x4, repeating
    prev = an;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (an == 4'hE && prev == 4'hB) found = 1'b1;
      prev = an;
    end
    check("scan_sync", {31'd0, found}, 32'd1);
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      case ((k % 12) / 4)
        0: exp_an = 4'hE;
        1: exp_an = 4'hD;
        default: exp_an = 4'hB;
      endcase
      check("scan_an", {28'd0, an}, {28'd0, exp_an});
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
